// File: rtl/ipc_notify_pkg.sv
// Shared constants and helpers for the Nios-to-master notification transmitter.
package ipc_notify_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DROP = 2'd2;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ipc_sync_fifo.sv
// Synchronous FIFO with registered head; flush beats push/pop, push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle, otherwise reported as a drop.
module ipc_sync_fifo
  import ipc_notify_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          head_dat_o,
  output logic                       head_vld_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [clog2(DEPTH):0]      count_o,
  output logic [clog2(DEPTH):0]      count_nxt_o,
  output logic                       drop_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_ok, push_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  always_comb begin
    pop_ok   = pop_i & ~empty_o & ~flush_i;
    push_ok  = push_i & ~flush_i & (~full_o | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Head reads 0 while empty so the master never sees stale words.
  assign head_dat_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign head_vld_o  = ~empty_o;
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign drop_o      = push_i & ~flush_i & full_o & ~pop_ok;

endmodule

// File: rtl/ipc_notify_tx.sv
// Nios-side notification transmitter: Avalon-MM register file, message FIFO,
// drop counter and level/pulse notify line toward the master.
module ipc_notify_tx
  import ipc_notify_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 8,
  parameter int PULSE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              m_pop,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              notify
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int PW = clog2(PULSE_CYCLES + 2);

  logic          wr_data, wr_ctrl, wr_drop;
  logic          flush, full, empty, drop;
  logic [CW-1:0] count, count_nxt;
  logic          enable_q, enable_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          level_q, level_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          trig, clr;
  logic          unused_wdata;

  assign wr_data = avs_write & (avs_address == ADDR_DATA);
  assign wr_ctrl = avs_write & (avs_address == ADDR_CTRL);
  assign wr_drop = avs_write & (avs_address == ADDR_DROP);
  assign flush   = wr_ctrl & avs_writedata[CTRL_FLUSH_BIT];
  assign unused_wdata = ^avs_writedata;

  ipc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (wr_data),
    .push_dat_i  (avs_writedata[DATA_W-1:0]),
    .pop_i       (m_pop),
    .flush_i     (flush),
    .head_dat_o  (m_data),
    .head_vld_o  (m_valid),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .drop_o      (drop)
  );

  always_comb begin
    enable_d = wr_ctrl ? avs_writedata[CTRL_EN_BIT] : enable_q;

    drop_cnt_d = drop_cnt_q;
    if (wr_drop)                           drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;

    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA: readdata_d = {16'b0, 8'(count), 6'b0, full, empty};
        ADDR_CTRL: readdata_d = {31'b0, enable_q};
        ADDR_DROP: readdata_d = {24'b0, drop_cnt_q};
        default:   readdata_d = '0;
      endcase
    end

    level_d = enable_d & (count_nxt != '0);

    // A push can only reach an empty FIFO when it cannot be full, so it is always accepted.
    trig = (wr_data & empty & enable_q)
         | (wr_ctrl & avs_writedata[CTRL_EN_BIT] & ~enable_q & ~empty);
    clr  = wr_ctrl & (~avs_writedata[CTRL_EN_BIT] | avs_writedata[CTRL_FLUSH_BIT]);

    pulse_d = pulse_q;
    if (clr)                  pulse_d = '0;
    else if (trig)            pulse_d = PW'(PULSE_CYCLES);
    else if (pulse_q != '0)   pulse_d = pulse_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= 1'b0;
      drop_cnt_q <= '0;
      readdata_q <= '0;
      level_q    <= 1'b0;
      pulse_q    <= '0;
    end else begin
      enable_q   <= enable_d;
      drop_cnt_q <= drop_cnt_d;
      readdata_q <= readdata_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign notify       = (PULSE_CYCLES == 0) ? level_q : (pulse_q != '0);

endmodule

// File: tb/tb_ipc_notify_tx.sv
// Level-mode and pulse-mode instances share one stimulus stream, checked against a queue model.
module tb_ipc_notify_tx;

  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam int PN  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          m_pop = 1'b0;
  logic [31:0]   rd_l, rd_p;
  logic [DW-1:0] md_l, md_p;
  logic          mv_l, mv_p, nt_l, nt_p;

  always #5 clk = ~clk;

  ipc_notify_tx #(.DATA_W(DW), .DEPTH(DEP), .PULSE_CYCLES(0)) u_lvl (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rd_l),
    .m_pop(m_pop), .m_data(md_l), .m_valid(mv_l), .notify(nt_l)
  );

  ipc_notify_tx #(.DATA_W(DW), .DEPTH(DEP), .PULSE_CYCLES(PN)) u_pls (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rd_p),
    .m_pop(m_pop), .m_data(md_p), .m_valid(mv_p), .notify(nt_p)
  );

  int total = 0;
  int bad   = 0;

  int unsigned q[$];
  bit          m_en;
  int          m_drop;
  int          m_rem;
  logic [31:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  push, ctrl, fl, pop_ok, trig, clr;
    if (reset) begin
      q.delete(); m_en = 0; m_drop = 0; m_rem = 0; m_rd = '0;
      return;
    end
    sz   = q.size();
    push = avs_write && avs_address == 2'd0;
    ctrl = avs_write && avs_address == 2'd1;
    fl   = ctrl && avs_writedata[1];
    if (avs_read) begin
      case (avs_address)
        2'd0: m_rd = (sz << 8) | ((sz == DEP) << 1) | (sz == 0);
        2'd1: m_rd = m_en;
        2'd2: m_rd = m_drop;
        default: m_rd = 0;
      endcase
    end
    trig = (push && sz == 0 && m_en) || (ctrl && avs_writedata[0] && !m_en && sz != 0);
    clr  = ctrl && (!avs_writedata[0] || avs_writedata[1]);
    if (fl) q.delete();
    else begin
      pop_ok = m_pop && sz > 0;
      if (pop_ok) void'(q.pop_front());
      if (push) begin
        if (sz < DEP || pop_ok) q.push_back(avs_writedata & 32'hFFFF);
        else if (m_drop < 255) m_drop++;
      end
    end
    if (avs_write && avs_address == 2'd2) m_drop = 0;
    if (ctrl) m_en = avs_writedata[0];
    if (clr) m_rem = 0;
    else if (trig) m_rem = PN;
    else if (m_rem > 0) m_rem--;
  endtask

  task automatic check_all();
    logic [31:0] head;
    head = (q.size() != 0) ? q[0] : 32'h0;
    chk("rdata_lvl", rd_l, m_rd);
    chk("rdata_pls", rd_p, m_rd);
    chk("valid_lvl", {31'b0, mv_l}, {31'b0, q.size() != 0});
    chk("valid_pls", {31'b0, mv_p}, {31'b0, q.size() != 0});
    chk("data_lvl", {16'b0, md_l}, head);
    chk("data_pls", {16'b0, md_p}, head);
    chk("notify_lvl", {31'b0, nt_l}, {31'b0, m_en && q.size() != 0});
    chk("notify_pls", {31'b0, nt_p}, {31'b0, m_rem != 0});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    avs_write = 0; avs_read = 0; m_pop = 0; reset = 0;
    avs_address = '0; avs_writedata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit p = 0);
    avs_write = 1; avs_address = a; avs_writedata = d; m_pop = p;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, input bit p = 0);
    avs_read = 1; avs_address = a; m_pop = p;
    tick();
  endtask

  task automatic idle(input bit p = 0);
    m_pop = p;
    tick();
  endtask

  task automatic rst();
    reset = 1;
    tick();
  endtask

  initial begin
    int hi;
    int r;

    // Reset and idle register reads
    rst(); rst();
    rd(0); chk("rst_status", rd_l, 32'h1);
    rd(1); chk("rst_ctrl", rd_l, 32'h0);
    chk("rst_notify", {31'b0, nt_l}, 32'h0);
    chk("rst_valid", {31'b0, mv_l}, 32'h0);

    // Level notify with two words
    wr(1, 32'h1);
    wr(0, 32'h3);
    chk("lvl_rise", {31'b0, nt_l}, 32'h1);
    chk("lvl_head0", {16'b0, md_l}, 32'h3);
    wr(0, 32'h5);
    idle(1); chk("lvl_head1", {16'b0, md_l}, 32'h5);
    idle(1);
    chk("lvl_empty", {31'b0, mv_l}, 32'h0);
    chk("lvl_fall", {31'b0, nt_l}, 32'h0);

    // Overfill, full push+pop, drop saturation
    for (int i = 0; i < 10; i++) wr(0, 32'h100 + i);
    rd(0); chk("full_status", rd_l, 32'h802);
    rd(2); chk("drop_two", rd_l, 32'h2);
    wr(0, 32'h99, 1);
    rd(0); chk("full_pushpop", rd_l, 32'h802);
    rd(2); chk("drop_still_two", rd_l, 32'h2);
    for (int i = 0; i < 260; i++) wr(0, $urandom);
    rd(2); chk("drop_sat", rd_l, 32'hFF);
    wr(2, 32'h0);
    rd(2); chk("drop_clear", rd_l, 32'h0);

    // Pulse mode: exactly PN cycles, no retrigger while non-empty
    for (int i = 0; i < DEP + 2; i++) idle(1);
    for (int i = 0; i < PN + 2; i++) idle();
    wr(0, 32'h7);
    hi = nt_p;
    for (int i = 0; i < PN + 2; i++) begin idle(); hi += nt_p; end
    chk("pulse_len", hi, PN);
    wr(0, 32'h8);
    hi = nt_p;
    for (int i = 0; i < PN + 1; i++) begin idle(); hi += nt_p; end
    chk("no_retrigger", hi, 0);
    idle(1); idle(1);
    wr(0, 32'h9);
    hi = nt_p;
    for (int i = 0; i < PN + 2; i++) begin idle(); hi += nt_p; end
    chk("pulse_again", hi, PN);

    // Flush at count 3 with a concurrent pop
    wr(0, 32'hA); wr(0, 32'hB);
    rd(2);
    wr(1, 32'h3, 1);
    chk("flush_notify", {31'b0, nt_l}, 32'h0);
    rd(0); chk("flush_status", rd_l, 32'h1);

    // Reset with count 5 and a pulse running
    for (int i = 0; i < 5; i++) wr(0, 32'h20 + i);
    wr(1, 32'h0);
    wr(1, 32'h1);
    chk("pulse_active", {31'b0, nt_p}, 32'h1);
    rst();
    chk("rst_mid_notify", {31'b0, nt_p}, 32'h0);
    chk("rst_mid_valid", {31'b0, mv_l}, 32'h0);
    rd(0); chk("rst_mid_status", rd_l, 32'h1);
    rd(2); chk("rst_mid_drop", rd_l, 32'h0);

    // Randomized traffic
    wr(1, 32'h1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      m_pop = ($urandom_range(0, 99) < 35);
      if (r < 40)       wr(0, $urandom, m_pop);
      else if (r < 52)  rd(2'($urandom_range(0, 3)), m_pop);
      else if (r < 60)  wr(1, {30'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)}, m_pop);
      else if (r < 63)  wr(2, $urandom, m_pop);
      else if (r < 65)  wr(3, $urandom, m_pop);
      else if (r < 66)  rst();
      else              idle(m_pop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
